// File: rtl/pc_if.sv
// pc_if: control and data bus of the program counter
interface pc_if #(
    parameter int WIDTH = 9
);
    logic             inc;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;

    modport master (output inc, output write, output read, output din, input dout);
    modport slave  (input inc, input write, input read, input din, output dout);
endinterface

// File: rtl/pc.sv
// pc: program counter with step increment, bus load and read-gated output
module pc #(
    parameter int               WIDTH     = 9,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic  clk,
    input logic  rst,
    pc_if.slave  bus
);
    logic [WIDTH-1:0] count;

    // load beats increment; reset clears immediately, independent of clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= RESET_VAL;
        else if (bus.write)
            count <= bus.din;
        else if (bus.inc)
            count <= count + WIDTH'(STEP);
    end

    // zero when not read so several sources can be OR-merged onto one bus
    assign bus.dout = bus.read ? count : '0;
endmodule

// File: tb/tb_pc.sv
// tb_pc: vector table, directed corner sequences and randomized model check
module tb_pc;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   model;

    pc_if #(.WIDTH(9)) bus ();

    pc #(.WIDTH(9), .STEP(1), .RESET_VAL(9'h000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       inc;
        logic       write;
        logic       read;
        logic [8:0] din;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic i, input logic w, input logic rd, input logic [8:0] d);
        rst = r;
        bus.inc = i;
        bus.write = w;
        bus.read = rd;
        bus.din = d;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        vecs = '{
            '{1'b1, 1'b0, 1'b0, 1'b1, 9'h000, 9'h000},
            '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 9'h000},
            '{1'b0, 1'b1, 1'b0, 1'b0, 9'h000, 9'h000},
            '{1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 9'h003},
            '{1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 9'h003},
            '{1'b0, 1'b0, 1'b1, 1'b1, 9'h00B, 9'h00B},
            '{1'b0, 1'b1, 1'b1, 1'b1, 9'h020, 9'h020},
            '{1'b0, 1'b0, 1'b1, 1'b1, 9'h1FF, 9'h1FF},
            '{1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 9'h000},
            '{1'b0, 1'b1, 1'b0, 1'b1, 9'h000, 9'h001},
            '{1'b0, 1'b0, 1'b1, 1'b1, 9'h055, 9'h055},
            '{1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 9'h000}
        };

        // reset is visible on dout before the first clock edge
        drive(1'b1, 1'b0, 1'b0, 1'b1, 9'h000);
        #1 check("reset_read1_noedge", bus.dout, 9'h000);
        bus.read = 1'b0;
        #1 check("reset_read0_noedge", bus.dout, 9'h000);

        // table vectors: drive on falling edge, check just after rising edge
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].inc, vecs[i].write, vecs[i].read, vecs[i].din);
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), bus.dout, vecs[i].exp);
        end

        // read gating without any clock edge; counter holds 0x055
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 9'h000);
        #1 check("gate_read1", bus.dout, 9'h055);
        bus.read = 1'b0;
        #1 check("gate_read0", bus.dout, 9'h000);
        bus.read = 1'b1;
        #1 check("gate_read1_again", bus.dout, 9'h055);
        @(posedge clk);
        #1 check("gate_hold_after_edge", bus.dout, 9'h055);

        // async reset mid-run cancels a pending increment
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 9'h0A0);
        @(posedge clk);
        #1 check("load_0a0", bus.dout, 9'h0A0);
        @(negedge clk);
        bus.write = 1'b0;
        bus.inc = 1'b1;
        #1 rst = 1'b1;
        #1 check("async_rst_immediate", bus.dout, 9'h000);
        repeat (2) @(posedge clk);
        #1 check("rst_held_no_inc", bus.dout, 9'h000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("first_inc_after_rst", bus.dout, 9'h001);

        // randomized traffic against an arithmetic reference model
        model = 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            drive(($urandom_range(0, 19) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0), 9'($urandom));
            if (n < 20) bus.din = 9'h1F0 + 9'(n);
            @(posedge clk);
            if (rst)
                model = 0;
            else if (bus.write)
                model = int'(bus.din);
            else if (bus.inc)
                model = (model + 1) % 512;
            #1 check("random", bus.dout, bus.read ? 9'(model) : 9'h000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
